reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
Consumes the PLL lock indication and the PLL output clock, and produces ordered, glitch-free synchronous reset releases for the rest of the SoC. Peripherals come out of reset first and the picorv32 core follows. Sits directly downstream of the rPLL wrapper. Re-asserts resets on PLL lock loss or on a software reset request from the CPU, and records the cause.

Parameters:
SYNC_STAGES, 2, flop count of the pll_lock synchronizer (>=2)
LOCK_STABLE_CYCLES, 1000, cycles lock must stay continuously high before reset sequencing (1..65536)
HOLD_CYCLES, 16, cycles both resets stay asserted after lock is stable (1..65536)
CPU_DELAY, 16, cycles between periph_reset_n release and sys_reset_n release (1..65536)

Ports:
clk  in  1  PLL output clock; all logic in this domain
reset_n  in  1  asynchronous, active-low board reset
pll_lock  in  1  PLL LOCK, asynchronous to clk
sw_reset_req  in  1  single-cycle synchronous pulse from CPU soft-reset register
periph_reset_n  out  1  active-low reset to peripherals (UART, GPIO, memory ctrl)
sys_reset_n  out  1  active-low reset to CPU core
reset_cause  out  2  0=external/power-on, 1=lock loss, 2=software, 3 unused
lock_loss_count  out  8  saturating count of lock losses seen while out of reset

Behaviour:
- reset_n low (async): state=WAIT_LOCK, cnt=0, sync flops=0, periph_reset_n=0, sys_reset_n=0, reset_cause=0, lock_loss_count=0. Release is handled synchronously by normal FSM progress.
- lock_s is the last stage of the SYNC_STAGES synchronizer on pll_lock. The FSM uses only lock_s.
- All outputs are registered and change on the same edge on which the FSM enters a state.
- 16-bit counter cnt; cleared on every state entry.
- WAIT_LOCK: both resets 0. If lock_s=1, go to STABLE.
- STABLE: both resets 0. If lock_s=0, go to WAIT_LOCK. Else if cnt==LOCK_STABLE_CYCLES-1, go to HOLD. Else cnt++.
- HOLD: both resets 0. If lock_s=0, go to WAIT_LOCK. Else if cnt==HOLD_CYCLES-1, go to PERIPH_UP. Else cnt++. sw_reset_req is ignored here.
- PERIPH_UP: periph_reset_n=1, sys_reset_n=0. If cnt==CPU_DELAY-1, go to RUN. Else cnt++.
- RUN: both resets 1.
- Lock loss exits from PERIPH_UP or RUN: lock_s=0 goes to WAIT_LOCK. Both resets return to 0 on that edge, reset_cause=1, lock_loss_count increments and saturates at 255.
- Software reset exits from PERIPH_UP or RUN: sw_reset_req=1 with lock_s=1 goes to HOLD with cnt=0 and both resets 0. reset_cause=2. This path skips STABLE.
- Simultaneous lock loss and sw_reset_req: lock loss wins. reset_cause=1.
- lock_loss_count is not incremented for lock drops in WAIT_LOCK, STABLE or HOLD.
- Lock glitch in STABLE restarts the full LOCK_STABLE_CYCLES wait.
- Worst-case assertion latency from pll_lock falling: SYNC_STAGES+1 edges.
- reset_cause and lock_loss_count persist across FSM-driven resets. Only reset_n clears them.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum: WAIT_LOCK, STABLE, HOLD, PERIPH_UP, RUN
  - cause constants: CAUSE_EXT=2'd0, CAUSE_LOCK=2'd1, CAUSE_SW=2'd2
  - counter width CNT_W=16
- One sub-module, cdc_sync: a parameterized N-stage single-bit synchronizer with async active-low clear. It is reusable for the button and UART RX inputs.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, CPU_DELAY=3. Edge 1 is the first clk rise after pll_lock rises.
1. Power-up: reset_n released, then pll_lock=1 -> STABLE entered at edge 3, periph_reset_n=1 at edge 15, sys_reset_n=1 at edge 18, reset_cause=0.
2. Lock glitch: pll_lock low for 1 cycle during STABLE -> return to WAIT_LOCK, full 8-cycle wait repeats, lock_loss_count stays 0.
3. Lock loss in RUN: pll_lock falls -> both resets 0 within 3 edges, reset_cause=1, lock_loss_count=1. Re-lock resequences as in scenario 1.
4. Software reset: 1-cycle sw_reset_req in RUN -> both resets 0 next edge, periph_reset_n=1 after 4 cycles, sys_reset_n=1 after a further 3 cycles, reset_cause=2. A request during HOLD is ignored.
5. Simultaneous sw_reset_req and lock loss in RUN -> reset_cause=1, FSM in WAIT_LOCK. Separately, 300 lock losses -> lock_loss_count=255.
6. reset_n pulsed low mid-PERIPH_UP -> outputs 0 asynchronously (before the next clk edge), counters and cause cleared, full sequence restarts.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    HOLD      = 3'd2,
    PERIPH_UP = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

endpackage

// File: rtl/cdc_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release after PLL lock: peripherals first, then the CPU.
// Re-asserts on lock loss or software request and records the cause.
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_LOCK | waiting for synchronized lock, both resets asserted
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES
// HOLD      | both resets held for HOLD_CYCLES with stable lock
// PERIPH_UP | peripherals released, CPU held for CPU_DELAY cycles
// RUN       | both resets released
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1000,
  parameter int HOLD_CYCLES        = 16,
  parameter int CPU_DELAY          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       sw_reset_req,
  output logic       periph_reset_n,
  output logic       sys_reset_n,
  output logic [1:0] reset_cause,
  output logic [7:0] lock_loss_count
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  // Sequencing FSM; outputs are registered alongside each state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      periph_reset_n  <= 1'b0;
      sys_reset_n     <= 1'b0;
      reset_cause     <= CAUSE_EXT;
      lock_loss_count <= 8'd0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lock_s) begin
            state <= STABLE;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state          <= PERIPH_UP;
            cnt            <= '0;
            periph_reset_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PERIPH_UP, RUN: begin
          // Lock loss takes priority over a coincident software request.
          if (!lock_s) begin
            state          <= WAIT_LOCK;
            cnt            <= '0;
            periph_reset_n <= 1'b0;
            sys_reset_n    <= 1'b0;
            reset_cause    <= CAUSE_LOCK;
            if (lock_loss_count != 8'hFF) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end else if (sw_reset_req) begin
            state          <= HOLD;
            cnt            <= '0;
            periph_reset_n <= 1'b0;
            sys_reset_n    <= 1'b0;
            reset_cause    <= CAUSE_SW;
          end else if (state == PERIPH_UP) begin
            if (cnt == CPU_LAST) begin
              state       <= RUN;
              cnt         <= '0;
              sys_reset_n <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state          <= WAIT_LOCK;
          cnt            <= '0;
          periph_reset_n <= 1'b0;
          sys_reset_n    <= 1'b0;
        end
      endcase
    end
  end

endmodule
